// File: rtl/mcu_timing_gen.sv
// Machine-cycle timing generator for the 8051 core: sequences S1P1..S6P2 and produces
// ALE, the machine-cycle tick, the instruction-done pulse and the multi-cycle index.
module mcu_timing_gen #(
   parameter int unsigned CLK_PER_PHASE = 1
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       hold,
   input  logic [2:0] instr_len,
   output logic [2:0] s_state,
   output logic       p_phase,
   output logic       ale,
   output logic       mc_tick,
   output logic [1:0] mc_index,
   output logic       instr_done,
   output logic       stalled
);

   localparam int unsigned CntW = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_PHASE - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      s_q, s_d;
   logic            p_q, p_d;
   logic            ale_q, ale_d;
   logic            tick_q, tick_d;
   logic [1:0]      idx_q, idx_d;
   logic            done_q, done_d;
   logic            stall_q, stall_d;
   logic [2:0]      len_q, len_d;

   logic terminal, boundary, wrap, advance, last_mc;
   logic [2:0] len_clamped;

   always_comb begin
      terminal = (cnt_q == CntMax);
      boundary = terminal && (s_q == 3'd6) && p_q;
      wrap     = boundary && !hold;
      // While held at the boundary the count stays terminal, so boundary is re-tested every clk.
      advance  = terminal && !(boundary && hold);
      last_mc  = ({1'b0, idx_q} == (len_q - 3'd1));

      unique case (instr_len)
         3'd0:                len_clamped = 3'd1;
         3'd1, 3'd2, 3'd3,
         3'd4:                len_clamped = instr_len;
         default:             len_clamped = 3'd4;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      s_d     = s_q;
      p_d     = p_q;
      idx_d   = idx_q;
      len_d   = len_q;
      done_d  = 1'b0;
      tick_d  = wrap;
      stall_d = boundary && hold;

      if (advance) begin
         cnt_d = '0;
         p_d   = ~p_q;
         if (p_q) begin
            s_d = (s_q == 3'd6) ? 3'd1 : s_q + 3'd1;
         end
      end else if (!terminal) begin
         cnt_d = cnt_q + CntW'(1);
      end

      if (wrap) begin
         if (last_mc) begin
            idx_d  = 2'd0;
            done_d = 1'b1;
            len_d  = len_clamped;
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end

      // Two strobes per machine cycle: S1P2-S2P1 and S4P2-S5P1.
      ale_d = ((s_d == 3'd1) &&  p_d) || ((s_d == 3'd2) && !p_d) ||
              ((s_d == 3'd4) &&  p_d) || ((s_d == 3'd5) && !p_d);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         s_q     <= 3'd1;
         p_q     <= 1'b0;
         ale_q   <= 1'b0;
         tick_q  <= 1'b0;
         idx_q   <= 2'd0;
         done_q  <= 1'b0;
         stall_q <= 1'b0;
         len_q   <= 3'd1;
      end else begin
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         p_q     <= p_d;
         ale_q   <= ale_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         stall_q <= stall_d;
         len_q   <= len_d;
      end
   end

   assign s_state    = s_q;
   assign p_phase    = p_q;
   assign ale        = ale_q;
   assign mc_tick    = tick_q;
   assign mc_index   = idx_q;
   assign instr_done = done_q;
   assign stalled    = stall_q;

endmodule

// File: doc/mcu_timing_gen.md
Name: mcu_timing_gen

Overview:
- Machine-cycle timing generator for the 8051 core. Sits directly downstream of the clock divider and runs on its divided clock.
- Sequences the 12 classic phases, S1P1 through S6P2, and emits the ALE strobe, a machine-cycle tick and an instruction-done pulse.
- Tracks multi-cycle instructions of 1-4 machine cycles.
- Provides a hold input that stalls the sequencer at a machine-cycle boundary. Fetch and execute logic consume these timing signals.

Parameters:
- CLK_PER_PHASE, 1: clk_in cycles per phase (P1 or P2). Legal range 1-16. Machine cycle = 12*CLK_PER_PHASE clk_in cycles.

Ports:
- clk_in  input  1  sequencer clock (divided clock); all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  stall request; honoured only at the machine-cycle boundary
- instr_len  input  3  machine cycles of the next instruction; sampled at the instruction boundary
- s_state  output  3  current state, 1..6 = S1..S6
- p_phase  output  1  0 = P1, 1 = P2
- ale  output  1  address latch enable
- mc_tick  output  1  one-clk pulse at the start of every machine cycle
- mc_index  output  2  index of the current machine cycle within the instruction, 0-based
- instr_done  output  1  one-clk pulse at the start of the first machine cycle of a new instruction
- stalled  output  1  high while frozen by hold

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - s_state=1, p_phase=0 (S1P1), prescale count=0
  - ale=0, mc_tick=0, instr_done=0, stalled=0, mc_index=0
  - internal length register len_q=1
- Prescaler:
  - Counts 0..CLK_PER_PHASE-1.
  - Phase advances on the clk_in where count = CLK_PER_PHASE-1. Count then wraps to 0.
  - CLK_PER_PHASE=1 advances the phase every clk.
- Phase order: S1P1, S1P2, S2P1, …, S6P2, then back to S1P1. p_phase toggles on each advance. s_state increments after each P2 and wraps 6 to 1.
- Boundary: the terminal clk of S6P2, i.e. S6P2 with count = CLK_PER_PHASE-1.
- Hold:
  - If hold=1 at the boundary: no advance. State stays S6P2, count stays terminal, stalled=1 from the next clk.
  - Sequencer re-evaluates every clk. The first clk with hold=0 advances to S1P1 and clears stalled.
  - hold asserted mid-cycle has no effect until the boundary. Deasserting it before the boundary means no stall.
- ale:
  - Registered and aligned with s_state/p_phase: high exactly while in S1P2, S2P1, S4P2 or S5P1, otherwise 0. That gives two strobes per machine cycle, each 2*CLK_PER_PHASE clks long.
  - ale=0 while stalled (state is S6P2).
- mc_tick: registered. High for exactly the first clk of every S1P1 reached from S6P2. Never high in the reset-state S1P1.
- Advance from S6P2 to S1P1:
  - If mc_index = len_q-1: mc_index goes to 0, instr_done pulses with mc_tick, and len_q loads from instr_len.
  - Otherwise: mc_index increments and instr_done stays 0.
- instr_len mapping when loaded: 0 → 1; 1-4 → as is; 5-7 → 4 (clamped).
- The first instruction after reset uses len_q=1.
- Mid-operation reset: all outputs take reset values immediately and asynchronously. Counting restarts at S1P1 after release.
- Latency: with no hold, mc_tick period = 12*CLK_PER_PHASE clks exactly. Each hold-clk past the boundary adds one clk.

Test Plan:
- Reset release, CLK_PER_PHASE=1, hold=0, instr_len=1 → s_state/p_phase step through S1P1..S6P2 over clks 0-11. At clk 12 state is S1P1 with mc_tick=1 and instr_done=1. After that, mc_tick repeats every 12 clks.
- ALE pattern, CLK_PER_PHASE=2 → ale high in clks 2-5 and 14-17 of each 24-clk machine cycle, low elsewhere. mc_tick period is 24.
- Multi-cycle instructions: instr_len=2 at first boundary, then 4, then 0, then 7 → mc_index sequences 0,1 | 0,1,2,3 | 0 | 0,1,2,3. instr_done pulses only when mc_index returns to 0.
- Hold at boundary: hold=1 from clk 8 to clk 15, CLK_PER_PHASE=1 → state frozen in S6P2 and stalled=1 from clk 12 through 15. At clk 16 the state is S1P1 with mc_tick=1 and stalled=0. Then verify hold pulsed only during clks 3-6 causes no stall.
- Async reset mid-S4 during a 4-cycle instruction with mc_index=2 → all outputs return to reset values without waiting for a clk edge. After release, mc_tick is first seen 12 clks later, and len_q=1.
